// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Fetch-PC generator for the RV32 core. Turns the EX-stage jump/branch decode plus the
//   branch_comp result into a PC redirect. A taken redirect also raises a timed flush that
//   squashes younger instructions. A misaligned target halts fetch until reset, because there
//   is no C extension.
//
// Parameters
//   RESET_PC      PC loaded on reset
//   FLUSH_CYCLES  cycles flush stays high after a redirect (1..7); stall stretches it
//
// Ports
//   clk, rst            core clock; synchronous active-high reset
//   stall               hazard freeze of the PC (a redirect still wins)
//   imem_ready          instruction memory accepted pc this cycle
//   is_branch/branch_in conditional branch in EX and its comparator result
//   is_jal/is_jalr      unconditional jumps in EX
//   ex_pc, imm          EX instruction PC and sign-extended immediate
//   rs1_data            forwarded JALR base
//   pc, pc_valid        fetch address and its validity
//   redirect            one-cycle pulse: pc was just loaded from a target
//   flush               squash IF/ID and ID/EX
//   link_addr           ex_pc + 4 (combinational)
//   misalign_exc        one-cycle pulse on a misaligned taken target
//   exc_pc              ex_pc of the faulting instruction
//   br_count/br_taken   branch statistics
//
// Build option
//   BRANCH_STATS_EN  when defined, br_count/br_taken are saturating counters; otherwise
//                    both ports are tied to zero and no counter flops exist.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        is_branch,
  input  logic        branch_in,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        flush,
  output logic [31:0] link_addr,
  output logic        misalign_exc,
  output logic [31:0] exc_pc,
  output logic [31:0] br_count,
  output logic [31:0] br_taken
);

  typedef enum logic [1:0] {StBoot, StRun, StFlush, StHalt} state_e;

  // The counter holds the number of flush cycles still to come after the current one.
  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pc_valid_q;
  logic        redirect_q;
  logic        flush_q;
  logic        misalign_q;
  logic [31:0] exc_pc_q;
  logic [2:0]  flush_cnt_q;

  logic        take;
  logic        advance;
  logic        misaligned;
  logic [31:0] target;

  // EX contents are only trusted in RUN. In the other states EX is empty or squashed.
  assign take       = (state_q == StRun) & ((is_branch & branch_in) | is_jal | is_jalr);
  assign target     = is_jalr ? ((rs1_data + imm) & ~32'h1) : (ex_pc + imm);
  assign misaligned = (target[1:0] != 2'b00);
  assign advance    = !stall && imem_ready;
  assign link_addr  = ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
      exc_pc_q    <= 32'h0;
      flush_cnt_q <= 3'd0;
    end else begin
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q    <= StRun;
          pc_valid_q <= 1'b1;
        end
        StRun: begin
          if (take && misaligned) begin
            // pc is left at the last legal fetch address for debug.
            state_q    <= StHalt;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b1;
            exc_pc_q   <= ex_pc;
            flush_q    <= 1'b1;
          end else if (take) begin
            state_q     <= StFlush;
            pc_q        <= target;
            redirect_q  <= 1'b1;
            flush_q     <= 1'b1;
            flush_cnt_q <= FlushLoad;
          end else if (advance) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        StFlush: begin
          if (advance) begin
            pc_q <= pc_q + 32'd4;
          end
          // A stalled pipeline still holds the squashed instructions, so the flush is held too.
          if (!stall) begin
            if (flush_cnt_q == 3'd0) begin
              state_q <= StRun;
              flush_q <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
        end
        StHalt: begin
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign redirect     = redirect_q;
  assign flush        = flush_q;
  assign misalign_exc = misalign_q;
  assign exc_pc       = exc_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] br_taken_q;
  logic        branch_eval;

  // Misaligned branches are counted as well: they were resolved even though they fault.
  assign branch_eval = (state_q == StRun) && is_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= 32'h0;
      br_taken_q <= 32'h0;
    end else if (branch_eval) begin
      if (br_count_q != 32'hFFFF_FFFF) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (branch_in && (br_taken_q != 32'hFFFF_FFFF)) begin
        br_taken_q <= br_taken_q + 32'd1;
      end
    end
  end

  assign br_count = br_count_q;
  assign br_taken = br_taken_q;
`else
  assign br_count = 32'h0;
  assign br_taken = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready, is_branch, branch_in, is_jal, is_jalr;
  logic [31:0] ex_pc, imm, rs1_data;
  logic [31:0] pc, link_addr, exc_pc, br_count, br_taken;
  logic        pc_valid, redirect, flush, misalign_exc;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .is_branch   (is_branch),
    .branch_in   (branch_in),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .ex_pc       (ex_pc),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .flush       (flush),
    .link_addr   (link_addr),
    .misalign_exc(misalign_exc),
    .exc_pc      (exc_pc),
    .br_count    (br_count),
    .br_taken    (br_taken)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=boot 1=running 2=halted; flush_rem counts unstalled flush
  // cycles still owed, starting from the cycle right after the redirect.
  int          m_phase      = 0;
  int          m_flush_rem  = 0;
  bit          m_halt_flush = 1'b0;
  bit          m_redirect   = 1'b0;
  bit          m_exc        = 1'b0;
  logic [31:0] m_pc         = RESET_PC;
  logic [31:0] m_exc_pc     = 32'h0;
  logic [31:0] m_cnt        = 32'h0;
  logic [31:0] m_tkn        = 32'h0;

  always @(posedge clk) begin
    longint unsigned a, b, s;
    bit tk;
    if (rst) begin
      m_phase = 0; m_flush_rem = 0; m_halt_flush = 0; m_redirect = 0; m_exc = 0;
      m_pc = RESET_PC; m_exc_pc = 0; m_cnt = 0; m_tkn = 0;
    end else begin
      m_redirect = 0; m_exc = 0; m_halt_flush = 0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1 && m_flush_rem > 0) begin
        if (!stall && imem_ready) m_pc = m_pc + 32'd4;
        if (!stall) m_flush_rem = m_flush_rem - 1;
      end else if (m_phase == 1) begin
        tk = (is_branch && branch_in) || is_jal || is_jalr;
        b  = imm;
        a  = is_jalr ? rs1_data : ex_pc;
        s  = (a + b) % 64'h1_0000_0000;
        if (is_jalr) s = s - (s % 2);
        if (is_branch) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (branch_in && m_tkn != 32'hFFFF_FFFF) m_tkn = m_tkn + 1;
        end
        if (tk && (s % 4) != 0) begin
          m_phase = 2; m_exc = 1; m_exc_pc = ex_pc; m_halt_flush = 1;
        end else if (tk) begin
          m_pc = s[31:0]; m_redirect = 1; m_flush_rem = FLUSH_CYCLES;
        end else if (!stall && imem_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      chk("model_pc", pc, m_pc);
      chk("model_pc_valid", 32'(pc_valid), 32'(m_phase == 1));
      chk("model_redirect", 32'(redirect), 32'(m_redirect));
      chk("model_flush", 32'(flush), 32'((m_flush_rem > 0) || m_halt_flush));
      chk("model_misalign", 32'(misalign_exc), 32'(m_exc));
      chk("model_exc_pc", exc_pc, m_exc_pc);
      chk("model_link", link_addr, ex_pc + 32'd4);
`ifdef BRANCH_STATS_EN
      chk("model_br_count", br_count, m_cnt);
      chk("model_br_taken", br_taken, m_tkn);
`else
      chk("model_br_count", br_count, 32'h0);
      chk("model_br_taken", br_taken, 32'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ex();
    is_branch = 0; branch_in = 0; is_jal = 0; is_jalr = 0;
  endtask

  initial begin
    rst = 1; stall = 0; imem_ready = 1; is_branch = 0; branch_in = 0; is_jal = 0;
    is_jalr = 0; ex_pc = 0; imm = 0; rs1_data = 0;

    // Reset and boot
    tick(); chk_en = 1; tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(pc_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    rst = 0;
    #1 chk("boot_valid", 32'(pc_valid), 32'h0);
    tick(); chk("run_pc0", pc, 32'h0); chk("run_valid", 32'(pc_valid), 32'h1);
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pcC", pc, 32'hC);

    // Taken branch; a misaligned jump presented during the flush must be ignored
    is_branch = 1; branch_in = 1; ex_pc = 32'h100; imm = 32'h40;
    tick(); chk("br_pc", pc, 32'h140); chk("br_redirect", 32'(redirect), 32'h1);
    chk("br_flush1", 32'(flush), 32'h1);
    clear_ex(); is_jal = 1; imm = 32'h6;
    tick(); chk("br_pc2", pc, 32'h144); chk("br_redirect_off", 32'(redirect), 32'h0);
    chk("br_flush2", 32'(flush), 32'h1); chk("br_ignored", 32'(misalign_exc), 32'h0);
    clear_ex();
    tick(); chk("br_pc3", pc, 32'h148); chk("br_flush_end", 32'(flush), 32'h0);

    // JALR clears the LSB of the target
    is_jalr = 1; rs1_data = 32'h2001; imm = 32'h3; ex_pc = 32'h300;
    #1 chk("jalr_link", link_addr, 32'h304);
    tick(); chk("jalr_pc", pc, 32'h2004); chk("jalr_redirect", 32'(redirect), 32'h1);
    clear_ex();
    tick(); tick(); chk("jalr_after", pc, 32'h200C);

    // Stall holds pc, a redirect overrides it and the flush stretches
    stall = 1;
    tick(); tick(); chk("stall_hold", pc, 32'h200C);
    is_branch = 1; branch_in = 1; ex_pc = 32'h400; imm = 32'hFFFF_FFF0;
    tick(); chk("stall_br_pc", pc, 32'h3F0); chk("stall_br_redir", 32'(redirect), 32'h1);
    clear_ex();
    tick(); tick(); chk("stall_flush", 32'(flush), 32'h1); chk("stall_pc_hold", pc, 32'h3F0);
    stall = 0;
    tick(); chk("stall_flush_tail", 32'(flush), 32'h1); chk("stall_pc_go", pc, 32'h3F4);
    tick(); chk("stall_flush_end", 32'(flush), 32'h0); chk("stall_pc_go2", pc, 32'h3F8);
    imem_ready = 0;
    tick(); chk("imem_hold", pc, 32'h3F8);
    imem_ready = 1;

    // Sequential wrap FFFF_FFFC -> 0
    is_jal = 1; ex_pc = 32'h10; imm = 32'hFFFF_FFE8;
    tick(); chk("wrap_tgt", pc, 32'hFFFF_FFF8);
    clear_ex();
    tick(); chk("wrap_fc", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_zero", pc, 32'h0);

    // Statistics: taken, not taken, taken; then reset during the flush
    rst = 1; tick(); rst = 0; tick();
    is_branch = 1; branch_in = 1; ex_pc = 32'h500; imm = 32'h8;
    tick(); chk("st_pc1", pc, 32'h508);
    clear_ex(); tick(); tick();
    is_branch = 1; branch_in = 0; ex_pc = 32'h600; imm = 32'h20;
    tick(); chk("st_nt_redirect", 32'(redirect), 32'h0); chk("st_nt_pc", pc, 32'h514);
    branch_in = 1;
    tick(); chk("st_pc3", pc, 32'h620);
    clear_ex();
`ifdef BRANCH_STATS_EN
    chk("st_count", br_count, 32'd3); chk("st_taken", br_taken, 32'd2);
`else
    chk("st_count", br_count, 32'd0); chk("st_taken", br_taken, 32'd0);
`endif
    rst = 1;
    tick(); chk("midrst_pc", pc, 32'h0); chk("midrst_flush", 32'(flush), 32'h0);
    chk("midrst_valid", 32'(pc_valid), 32'h0); chk("midrst_count", br_count, 32'h0);
    rst = 0; tick(); tick(); chk("pre_mis_pc", pc, 32'h4);

    // Misaligned JAL halts fetch until reset
    is_jal = 1; ex_pc = 32'h200; imm = 32'h6;
    tick(); chk("mis_exc", 32'(misalign_exc), 32'h1); chk("mis_exc_pc", exc_pc, 32'h200);
    chk("mis_pc", pc, 32'h4); chk("mis_valid", 32'(pc_valid), 32'h0);
    chk("mis_flush", 32'(flush), 32'h1); chk("mis_redirect", 32'(redirect), 32'h0);
    tick(); chk("mis_exc_pulse", 32'(misalign_exc), 32'h0); chk("mis_flush_end", 32'(flush), 32'h0);
    tick(); chk("halt_pc", pc, 32'h4); chk("halt_valid", 32'(pc_valid), 32'h0);
    clear_ex();

    // Misaligned taken branch is still counted
    rst = 1; tick(); rst = 0; tick();
    is_branch = 1; branch_in = 1; ex_pc = 32'h40; imm = 32'h22;
    tick(); chk("misbr_exc", 32'(misalign_exc), 32'h1); chk("misbr_exc_pc", exc_pc, 32'h40);
`ifdef BRANCH_STATS_EN
    chk("misbr_count", br_count, 32'd1);
`else
    chk("misbr_count", br_count, 32'd0);
`endif
    clear_ex();

    // JALR whose bit 1 survives the LSB clear
    rst = 1; tick(); rst = 0; tick();
    is_jalr = 1; rs1_data = 32'h1000; imm = 32'h2; ex_pc = 32'h80;
    tick(); chk("misjalr_exc", 32'(misalign_exc), 32'h1); chk("misjalr_pc", exc_pc, 32'h80);
    clear_ex();
    tick();

    chk_en = 0;
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
